// File: rtl/fft_output_streamer.sv
// Captures one frame of packed FFT results on a load strobe and streams the bins
// out over a valid/ready port, optionally in bit-reversed slot order.
module fft_output_streamer #(
  parameter int N           = 16,
  parameter int W           = 16,
  parameter int BIT_REVERSE = 0,
  localparam int IW         = $clog2(N)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            load,
  input  logic [N*W-1:0]  xout_bus,
  input  logic [N*W-1:0]  yout_bus,
  output logic            s_valid,
  input  logic            s_ready,
  output logic [W-1:0]    s_re,
  output logic [W-1:0]    s_im,
  output logic [IW-1:0]   s_index,
  output logic            s_last,
  output logic            busy,
  output logic            done,
  output logic            overrun
);

  typedef enum logic {IDLE, STREAM} state_t;

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  state_t         state;
  logic [W-1:0]   x_in   [N];
  logic [W-1:0]   y_in   [N];
  logic [W-1:0]   re_mem [N];
  logic [W-1:0]   im_mem [N];
  logic [IW-1:0]  next_idx;
  logic           xfer;
  logic           accept;

  // Map an output bin number to the capture slot that feeds it.
  function automatic logic [IW-1:0] slot_of(input logic [IW-1:0] k);
    logic [IW-1:0] r;
    r = k;
    if (BIT_REVERSE != 0) begin
      for (int i = 0; i < IW; i++) r[i] = k[IW-1-i];
    end
    return r;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_unpack
    assign x_in[gi] = xout_bus[gi*W +: W];
    assign y_in[gi] = yout_bus[gi*W +: W];
  end

  assign next_idx = s_index + IW'(1);
  assign xfer     = (state == STREAM) && s_ready;
  // A load is taken in IDLE, or when it coincides with the final transfer.
  assign accept   = load && ((state == IDLE) || (xfer && s_last));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      s_valid <= 1'b0;
      s_re    <= '0;
      s_im    <= '0;
      s_index <= '0;
      s_last  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      overrun <= 1'b0;
      for (int k = 0; k < N; k++) begin
        re_mem[k] <= '0;
        im_mem[k] <= '0;
      end
    end else begin
      done <= xfer && s_last;

      if (load && !accept) overrun <= 1'b1;

      if (accept) begin
        for (int k = 0; k < N; k++) begin
          re_mem[k] <= x_in[k];
          im_mem[k] <= y_in[k];
        end
        // Bin 0 comes straight off the bus so it is valid on the next cycle.
        state   <= STREAM;
        s_valid <= 1'b1;
        busy    <= 1'b1;
        s_index <= '0;
        s_last  <= (LAST_IDX == '0);
        s_re    <= x_in[slot_of('0)];
        s_im    <= y_in[slot_of('0)];
      end else if (xfer) begin
        if (s_last) begin
          state   <= IDLE;
          s_valid <= 1'b0;
          busy    <= 1'b0;
          s_last  <= 1'b0;
          s_index <= '0;
        end else begin
          s_index <= next_idx;
          s_last  <= (next_idx == LAST_IDX);
          s_re    <= re_mem[slot_of(next_idx)];
          s_im    <= im_mem[slot_of(next_idx)];
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_output_streamer.sv
// Directed bench for fft_output_streamer: straight and bit-reversed instances
// share load/ready so both stream in lockstep.
module tb_fft_output_streamer;
  localparam int N = 16;
  localparam int W = 16;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic           load = 1'b0;
  logic           s_ready = 1'b0;
  logic [N*W-1:0] xb = '0, yb = '0, xbr = '0, ybr = '0;

  logic           s_valid, s_last, busy, done, overrun;
  logic [W-1:0]   s_re, s_im;
  logic [3:0]     s_index;
  logic           br_valid, br_last, br_busy, br_done, br_overrun;
  logic [W-1:0]   br_re, br_im;
  logic [3:0]     br_index;

  int checks = 0;
  int failures = 0;
  int br_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  fft_output_streamer #(.N(N), .W(W), .BIT_REVERSE(0)) dut (
    .clock(clock), .reset_n(reset_n), .load(load),
    .xout_bus(xb), .yout_bus(yb),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .s_index(s_index), .s_last(s_last), .busy(busy), .done(done),
    .overrun(overrun)
  );

  fft_output_streamer #(.N(N), .W(W), .BIT_REVERSE(1)) dut_br (
    .clock(clock), .reset_n(reset_n), .load(load),
    .xout_bus(xbr), .yout_bus(ybr),
    .s_valid(br_valid), .s_ready(s_ready), .s_re(br_re), .s_im(br_im),
    .s_index(br_index), .s_last(br_last), .busy(br_busy), .done(br_done),
    .overrun(br_overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic frame1();
    for (int k = 0; k < N; k++) begin
      xb[k*W +: W] = 16'(100 + k);
      yb[k*W +: W] = 16'(-k);
    end
  endtask

  task automatic frame2();
    for (int k = 0; k < N; k++) begin
      xb[k*W +: W] = 16'hFED4;  // -300
      yb[k*W +: W] = 16'd7;
    end
  endtask

  task automatic load_pulse();
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_valid"}, 16'(s_valid), 16'd0);
    check({pfx, "_re"}, s_re, 16'd0);
    check({pfx, "_im"}, s_im, 16'd0);
    check({pfx, "_index"}, 16'(s_index), 16'd0);
    check({pfx, "_last"}, 16'(s_last), 16'd0);
    check({pfx, "_busy"}, 16'(busy), 16'd0);
    check({pfx, "_done"}, 16'(done), 16'd0);
    check({pfx, "_overrun"}, 16'(overrun), 16'd0);
  endtask

  initial begin
    int got;
    logic stall;
    logic [15:0] prev_re;
    logic [3:0]  prev_idx;

    for (int k = 0; k < N; k++) begin
      xbr[k*W +: W] = 16'(k);
      ybr[k*W +: W] = 16'(256 + k);
    end

    // Reset
    step(); step();
    check_zero_outputs("rst");
    reset_n = 1'b1;
    step();
    check("idle_valid", 16'(s_valid), 16'd0);

    // Straight frame plus bit-reversed instance, ready held high
    frame1();
    s_ready = 1'b1;
    load_pulse();
    xb = {N{16'hAAAA}};  // bus changes after load must not matter
    for (int k = 0; k < N; k++) begin
      $display("bin idx=%0d re=%0d im=%0d br_re=%0d", s_index, $signed(s_re), $signed(s_im), br_re);
      check("f1_valid", 16'(s_valid), 16'd1);
      check("f1_busy", 16'(busy), 16'd1);
      check("f1_index", 16'(s_index), 16'(k));
      check("f1_re", s_re, 16'(100 + k));
      check("f1_im", s_im, 16'(-k));
      check("f1_last", 16'(s_last), 16'(k == N - 1));
      check("br_re", br_re, 16'(br_tab[k]));
      check("br_im", br_im, 16'(256 + br_tab[k]));
      check("br_index", 16'(br_index), 16'(k));
      step();
    end
    check("f1_done", 16'(done), 16'd1);
    check("f1_busy_end", 16'(busy), 16'd0);
    check("f1_valid_end", 16'(s_valid), 16'd0);
    check("br_done", 16'(br_done), 16'd1);
    step();
    check("f1_done_1cyc", 16'(done), 16'd0);

    // Backpressure: ready pattern 1,0,0,1,0,0,...
    frame1();
    load_pulse();
    got = 0;
    stall = 1'b0;
    prev_re = '0;
    prev_idx = '0;
    for (int cyc = 0; cyc < 200 && got < N; cyc++) begin
      if (stall) begin
        check("bp_hold_valid", 16'(s_valid), 16'd1);
        check("bp_hold_re", s_re, prev_re);
        check("bp_hold_index", 16'(s_index), 16'(prev_idx));
      end
      s_ready = (cyc % 3 == 0);
      if (s_valid && s_ready) begin
        $display("bp xfer idx=%0d re=%0d", s_index, $signed(s_re));
        check("bp_re", s_re, 16'(100 + got));
        check("bp_index", 16'(s_index), 16'(got));
        got++;
      end
      stall = s_valid && !s_ready;
      prev_re = s_re;
      prev_idx = s_index;
      step();
    end
    check("bp_count", 16'(got), 16'(N));
    check("bp_done", 16'(done), 16'd1);
    s_ready = 1'b1;
    step();

    // Back-to-back: new frame loaded with the final transfer
    frame1();
    load_pulse();
    for (int k = 0; k < N - 1; k++) step();
    check("b2b_at_last", 16'(s_index), 16'd15);
    frame2();
    load_pulse();
    $display("b2b idx=%0d re=%0d im=%0d", s_index, $signed(s_re), $signed(s_im));
    check("b2b_valid", 16'(s_valid), 16'd1);
    check("b2b_index", 16'(s_index), 16'd0);
    check("b2b_re", s_re, 16'hFED4);
    check("b2b_im", s_im, 16'd7);
    check("b2b_done", 16'(done), 16'd1);
    check("b2b_overrun", 16'(overrun), 16'd0);
    for (int k = 0; k < N; k++) begin
      check("b2b_f2_re", s_re, 16'hFED4);
      check("b2b_f2_index", 16'(s_index), 16'(k));
      step();
    end
    check("b2b_f2_done", 16'(done), 16'd1);
    step();

    // Overrun: load during bin 6 is ignored and latched as overrun
    frame1();
    load_pulse();
    for (int k = 0; k < 6; k++) step();
    check("ov_at6", 16'(s_index), 16'd6);
    xb = {N{16'd999}};
    load_pulse();
    check("ov_flag", 16'(overrun), 16'd1);
    for (int k = 7; k < N; k++) begin
      check("ov_re", s_re, 16'(100 + k));
      check("ov_index", 16'(s_index), 16'(k));
      step();
    end
    check("ov_done", 16'(done), 16'd1);
    step(); step();
    check("ov_sticky", 16'(overrun), 16'd1);
    check("ov_idle", 16'(s_valid), 16'd0);

    // Asynchronous reset mid-frame
    frame1();
    load_pulse();
    for (int k = 0; k < 9; k++) step();
    check("mr_at9", 16'(s_index), 16'd9);
    reset_n = 1'b0;
    #1;
    check_zero_outputs("mr");
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("mr_quiet", 16'(s_valid), 16'd0);
    end
    load_pulse();
    check("mr_new_valid", 16'(s_valid), 16'd1);
    check("mr_new_index", 16'(s_index), 16'd0);
    check("mr_new_re", s_re, 16'd100);
    got = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (s_valid) got++;
      step();
    end
    check("mr_frame_len", 16'(got), 16'(N));
    check("mr_done", 16'(done), 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
